// File: rtl/mem_arbiter_types.sv
// +----------------------------------------------------------------------------+
// | Package     : mem_arbiter_types                                            |
// | Description : Shared types and reset constants for the instruction/data    |
// |               memory-port arbiter.                                         |
// | Contents    : arb_state_t  - arbiter FSM state (IDLE, I_BUSY, D_BUSY)       |
// |               mem_word_t   - 16-bit memory word / address                  |
// |               mem_be_t     - 2-bit byte-lane mask                          |
// |               RST_*        - reset values of the registered memory port    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_arbiter_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  typedef logic [15:0] mem_word_t;
  typedef logic [1:0]  mem_be_t;

  localparam mem_word_t RST_ADDR  = 16'h0000;
  localparam mem_word_t RST_WDATA = 16'h0000;
  localparam mem_be_t   RST_BE    = 2'b00;
  // Priority pointer reset value: 1 means the data side is preferred.
  localparam logic      RST_PTR_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_arb_pick.sv
// +----------------------------------------------------------------------------+
// | Module      : arb_pick                                                     |
// | Description : Combinational winner select between the instruction and     |
// |               data requesters. A lone requester always wins; on a          |
// |               collision the side named by the pointer wins.                |
// | Ports       : i_pending (in)  instruction side has read|write asserted     |
// |               d_pending (in)  data side has read|write asserted            |
// |               pointer   (in)  1 = data side wins a collision, 0 = instr.   |
// |               grant_i   (out) instruction side selected                    |
// |               grant_d   (out) data side selected                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module arb_pick (
  input  logic i_pending,
  input  logic d_pending,
  input  logic pointer,
  output logic grant_i,
  output logic grant_d
);

  // The two grants are mutually exclusive by construction.
  assign grant_d = d_pending & (~i_pending |  pointer);
  assign grant_i = i_pending & (~d_pending | ~pointer);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Merges the instruction-side (i_*) and data-side (d_*)        |
// |               request ports onto one multi-cycle single-port memory        |
// |               (mem_*). One transaction is outstanding at a time; the grant |
// |               is held until mem_resp, which is routed back to the owner.   |
// | Parameters  : ADDR_W - address width, DATA_W - data width (bytes = /8)     |
// | Ports       : clk, rst           clock, synchronous active-high reset      |
// |               i_read/i_write     instruction request, held until i_resp    |
// |               i_byte_enable/i_address/i_wdata   instruction request data   |
// |               i_rdata/i_resp     instruction read data / completion pulse  |
// |               d_*                same set for the data side                |
// |               mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata     |
// |                                  registered request to physical memory     |
// |               mem_rdata/mem_resp read data / completion from memory        |
// | Options     : MEM_ARBITER_ROUND_ROBIN_EN - when defined, collisions are     |
// |               resolved by a pointer that toggles on every grant; otherwise |
// |               the data side always wins a collision.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_arbiter_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [DATA_W/8-1:0]   i_byte_enable,
  input  logic [ADDR_W-1:0]     i_address,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_resp,

  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_W/8-1:0]   d_byte_enable,
  input  logic [ADDR_W-1:0]     d_address,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_resp,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_W/8-1:0]   mem_byte_enable,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t state;

  logic i_pending;
  logic d_pending;
  logic prio_d;
  logic grant_i;
  logic grant_d;
  logic in_idle;

  assign i_pending = i_read | i_write;
  assign d_pending = d_read | d_write;
  assign in_idle   = (state == IDLE);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic ptr_d;

  // Toggles on every grant, including a grant to a lone requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_d <= RST_PTR_D;
    end else if (in_idle && (grant_i || grant_d)) begin
      ptr_d <= ~ptr_d;
    end
  end

  assign prio_d = ptr_d;
`else
  assign prio_d = 1'b1;
`endif

  arb_pick u_arb_pick (
    .i_pending (i_pending),
    .d_pending (d_pending),
    .pointer   (prio_d),
    .grant_i   (grant_i),
    .grant_d   (grant_d)
  );

  // The memory request is captured on the granting edge and then held, so
  // the requester may change or drop its inputs without disturbing memory.
  // Write takes precedence when a requester raises read and write together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= (DATA_W/8)'(RST_BE);
      mem_address     <= ADDR_W'(RST_ADDR);
      mem_wdata       <= DATA_W'(RST_WDATA);
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state           <= D_BUSY;
            mem_write       <= d_write;
            mem_read        <= d_read & ~d_write;
            mem_byte_enable <= d_byte_enable;
            mem_address     <= d_address;
            mem_wdata       <= d_wdata;
          end else if (grant_i) begin
            state           <= I_BUSY;
            mem_write       <= i_write;
            mem_read        <= i_read & ~i_write;
            mem_byte_enable <= i_byte_enable;
            mem_address     <= i_address;
            mem_wdata       <= i_wdata;
          end
        end
        I_BUSY, D_BUSY: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // A completion arriving in the reset cycle is an aborted transaction and
  // must not reach the requester; mem_resp seen in IDLE has no owner.
  assign i_resp  = ~rst & mem_resp & (state == I_BUSY);
  assign d_resp  = ~rst & mem_resp & (state == D_BUSY);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

`default_nettype wire
